// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC engine control path: engine bundles, job descriptor
// and the job sequencer state encoding.
package mac_package;
  localparam int MAC_CNT_LEN = 16;
  localparam int LEN_W       = $clog2(MAC_CNT_LEN) + 1;
  localparam int SHIFT_W     = 5;

  typedef struct packed {
    logic               clear;
    logic               enable;
    logic               start;
    logic               simple_mul;
    logic [SHIFT_W-1:0] shift;
    logic [LEN_W-1:0]   len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [LEN_W-1:0] cnt;
  } flags_engine_t;

  typedef struct packed {
    logic               simple_mul;
    logic [SHIFT_W-1:0] shift;
    logic [LEN_W-1:0]   len;
  } mac_job_t;

  typedef enum logic [2:0] {IDLE, CLEAR, START, RUN, DONE} mac_ctrl_state_t;

  // A dot product yields one result; simple multiply yields one per element.
  function automatic logic [LEN_W-1:0] exp_outputs(mac_job_t j);
    return j.simple_mul ? j.len : LEN_W'(1);
  endfunction
endpackage

// File: rtl/mac_ctrl_if.sv
// Job handshake and engine-side signals of mac_ctrl; slave is the sequencer,
// master is whoever feeds jobs and models the engine.
interface mac_ctrl_if;
  import mac_package::*;
  logic          job_valid_i;
  logic          job_ready_o;
  mac_job_t      job_i;
  ctrl_engine_t  ctrl_engine_o;
  flags_engine_t flags_engine_i;
  logic          d_valid_i;
  logic          d_ready_i;

  modport slave (input job_valid_i, job_i, flags_engine_i, d_valid_i, d_ready_i,
                 output job_ready_o, ctrl_engine_o);
  modport master(output job_valid_i, job_i, flags_engine_i, d_valid_i, d_ready_i,
                 input job_ready_o, ctrl_engine_o);
endinterface

// File: rtl/mac_ctrl_watchdog.sv
// RUN-phase stall detector for mac_ctrl; only compiled with MAC_CTRL_TIMEOUT_EN.
`ifdef MAC_CTRL_TIMEOUT_EN
module mac_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic hs_i,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // The abort is decided on the last counting cycle and registered, so the
  // engine stream never reaches ctrl_engine_o combinationally; a handshake on
  // that deciding cycle still cancels the abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else if (!run_i || hs_i || timeout_o) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 1'b1;
      timeout_o <= (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  end
endmodule
`endif

// File: rtl/mac_ctrl.sv
// Job-level sequencer for the MAC engine: CLEAR -> START -> RUN -> DONE per job.
// Optional RUN watchdog enabled by defining MAC_CTRL_TIMEOUT_EN.
module mac_ctrl
  import mac_package::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  mac_ctrl_if.slave        bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  mac_ctrl_state_t  state_q, state_d;
  mac_job_t         cfg_q;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_inc;
  logic             job_ready, accept, hs, last_hs, timeout;

  assign job_ready   = (state_q == IDLE) & ~clear_i;
  assign accept      = bus.job_valid_i & job_ready;
  assign hs          = (state_q == RUN) & bus.d_valid_i & bus.d_ready_i;
  assign out_cnt_inc = (&out_cnt_q) ? out_cnt_q : out_cnt_q + 1'b1;
  assign last_hs     = hs & (out_cnt_inc == exp_outputs(cfg_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i)     cfg_q <= '0;
      else if (accept) cfg_q <= bus.job_i;
      if (accept)      out_cnt_q <= '0;
      else if (hs)     out_cnt_q <= out_cnt_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus.job_i.len == '0) ? DONE : CLEAR;
      CLEAR:   state_d = START;
      START:   state_d = RUN;
      RUN:     if (timeout) state_d = IDLE;
               else if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    bus.ctrl_engine_o            = '0;
    bus.ctrl_engine_o.clear      = (state_q == CLEAR) | clear_i | timeout;
    bus.ctrl_engine_o.enable     = (state_q == START) | (state_q == RUN);
    bus.ctrl_engine_o.start      = (state_q == START);
    bus.ctrl_engine_o.simple_mul = cfg_q.simple_mul;
    bus.ctrl_engine_o.shift      = cfg_q.shift;
    bus.ctrl_engine_o.len        = cfg_q.len;
  end

  assign bus.job_ready_o = job_ready;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE) & ~clear_i;

  // Engine count is observation-only for this block.
  logic unused_flags;
  assign unused_flags = ^bus.flags_engine_i;

`ifdef MAC_CTRL_TIMEOUT_EN
  logic wd_run;
  assign wd_run = (state_q == RUN) & ~clear_i;
  mac_ctrl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .run_i    (wd_run),
    .hs_i     (hs),
    .timeout_o(timeout)
  );
  assign err_o = timeout;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif
endmodule

// File: tb/tb_mac_ctrl.sv
// Scoreboard bench for mac_ctrl: expected done events are queued when the final
// output handshake is driven and consumed when done_o fires.
module tb_mac_ctrl;
  import mac_package::*;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic busy, done, err;
  mac_ctrl_if bus();

  mac_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {int cyc; int len;} exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_len", int'(bus.ctrl_engine_o.len), e.len);
      end
    end
  end

`ifndef MAC_CTRL_TIMEOUT_EN
  always @(negedge clk) if (err) chk("err_tied_low", int'(err), 0);
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic sm, input int ln);
    bus.job_valid_i = 1'b1;
    bus.job_i.simple_mul = sm;
    bus.job_i.shift = SHIFT_W'(1);
    bus.job_i.len = LEN_W'(ln);
    @(negedge clk);
    tick();
    bus.job_valid_i = 1'b0;
  endtask

  // Runs one job from acceptance; returns in the cycle after DONE (H+2).
  task automatic run_job(input logic sm, input int sh, input int ln, input bit bp,
                         input bit nxt, input int nsh, input int nln,
                         output int t, output int h);
    int need, got, k;
    h = -1;
    bus.job_valid_i = 1'b1;
    bus.job_i.simple_mul = sm;
    bus.job_i.shift = SHIFT_W'(sh);
    bus.job_i.len = LEN_W'(ln);
    @(negedge clk);
    chk("job_ready", int'(bus.job_ready_o), 1);
    chk("idle_busy", int'(busy), 0);
    t = cyc;
    tick();
    bus.job_valid_i = 1'b0;
    if (ln == 0) begin
      sb.push_back('{t + 1, 0});
      @(negedge clk);
      chk("zero_clear", int'(bus.ctrl_engine_o.clear), 0);
      chk("zero_enable", int'(bus.ctrl_engine_o.enable), 0);
      chk("zero_start", int'(bus.ctrl_engine_o.start), 0);
      chk("zero_busy", int'(busy), 1);
      h = t;
      tick();
      return;
    end
    @(negedge clk);
    chk("clr_clear", int'(bus.ctrl_engine_o.clear), 1);
    chk("clr_enable", int'(bus.ctrl_engine_o.enable), 0);
    chk("clr_shift", int'(bus.ctrl_engine_o.shift), sh);
    chk("clr_len", int'(bus.ctrl_engine_o.len), ln);
    chk("clr_smul", int'(bus.ctrl_engine_o.simple_mul), int'(sm));
    tick();
    @(negedge clk);
    chk("st_start", int'(bus.ctrl_engine_o.start), 1);
    chk("st_enable", int'(bus.ctrl_engine_o.enable), 1);
    chk("st_clear", int'(bus.ctrl_engine_o.clear), 0);
    tick();
    need = sm ? ln : 1;
    got = 0;
    k = 0;
    while (got < need && k < 200) begin
      bus.d_valid_i = 1'b1;
      bus.d_ready_i = bp ? (k % 2 == 1) : 1'b1;
      if (bus.d_ready_i) got++;
      if (got == need) begin
        h = cyc;
        sb.push_back('{cyc + 1, ln});
      end
      @(negedge clk);
      chk("run_enable", int'(bus.ctrl_engine_o.enable), 1);
      chk("run_start", int'(bus.ctrl_engine_o.start), 0);
      tick();
      k++;
    end
    if (got < need) chk("run_bound", got, need);
    bus.d_valid_i = 1'b0;
    bus.d_ready_i = 1'b1;
    if (nxt) begin
      bus.job_valid_i = 1'b1;
      bus.job_i.simple_mul = 1'b0;
      bus.job_i.shift = SHIFT_W'(nsh);
      bus.job_i.len = LEN_W'(nln);
    end
    @(negedge clk);
    chk("done_enable", int'(bus.ctrl_engine_o.enable), 0);
    chk("done_busy", int'(busy), 1);
    if (nxt) begin
      chk("b2b_not_ready", int'(bus.job_ready_o), 0);
      chk("b2b_old_shift", int'(bus.ctrl_engine_o.shift), sh);
      chk("b2b_old_len", int'(bus.ctrl_engine_o.len), ln);
    end
    tick();
  endtask

  int t, h, t2, h2;

  initial begin
    bus.job_valid_i = 1'b0;
    bus.job_i = '0;
    bus.flags_engine_i = '0;
    bus.d_valid_i = 1'b0;
    bus.d_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ctrl", int'(bus.ctrl_engine_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(bus.job_ready_o), 1);
    tick();

    // Dot product: single output, handshake on first RUN cycle
    run_job(1'b0, 2, 4, 1'b0, 1'b0, 0, 0, t, h);
    chk("scalar_hs_cycle", h, t + 3);

    // Simple multiply with backpressure: done only after the third handshake
    run_job(1'b1, 1, 3, 1'b1, 1'b0, 0, 0, t, h);
    chk("smul_hs_cycle", h, t + 3 + 5);

    // Backpressure followed by a queued second job
    run_job(1'b1, 3, 2, 1'b1, 1'b1, 7, 5, t, h);
    run_job(1'b0, 7, 5, 1'b0, 1'b0, 0, 0, t2, h2);
    chk("b2b_accept", t2, h + 2);

    // No-op job
    run_job(1'b0, 4, 0, 1'b0, 1'b0, 0, 0, t, h);

    // Abort in RUN after one of three outputs
    accept(1'b1, 3);
    tick();
    tick();
    bus.d_valid_i = 1'b1;
    tick();
    bus.d_valid_i = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("abort_clear", int'(bus.ctrl_engine_o.clear), 1);
    chk("abort_busy", int'(busy), 1);
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    chk("abort_cfg_len", int'(bus.ctrl_engine_o.len), 0);
    chk("abort_ready", int'(bus.job_ready_o), 1);
    repeat (3) tick();

    // clear_i beats job_valid_i in IDLE
    clear = 1'b1;
    bus.job_valid_i = 1'b1;
    bus.job_i.len = LEN_W'(2);
    @(negedge clk);
    chk("clrjob_ready", int'(bus.job_ready_o), 0);
    chk("clrjob_clear", int'(bus.ctrl_engine_o.clear), 1);
    tick();
    clear = 1'b0;
    bus.job_valid_i = 1'b0;
    @(negedge clk);
    chk("clrjob_not_taken", int'(busy), 0);
    tick();

    // Reset mid-job
    accept(1'b0, 1);
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", int'(bus.ctrl_engine_o), 0);
    chk("midrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // RUN with the engine stream stalled
    accept(1'b0, 2);
    tick();
    tick();
`ifdef MAC_CTRL_TIMEOUT_EN
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("wd_err", int'(err), (k == 16) ? 1 : 0);
      chk("wd_clear", int'(bus.ctrl_engine_o.clear), (k == 16) ? 1 : 0);
      tick();
    end
    @(negedge clk);
    chk("wd_idle", int'(busy), 0);
    tick();
`else
    repeat (1000) tick();
    @(negedge clk);
    chk("stall_busy", int'(busy), 1);
    chk("stall_enable", int'(bus.ctrl_engine_o.enable), 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("stall_abort_idle", int'(busy), 0);
    tick();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
